xrv1_mem_arb: RTL and testbench
===============================

# xrv1_mem_arb

Two-to-one memory arbiter that lets the XRV1 core's instruction-fetch port and data port share a single memory port, such as a unified single-port TCM or an external bus bridge. It sits between `xrv1_core` and the memory model and uses the same valid/ready request and valid-only response protocol on all three sides. Conflicting requests are arbitrated round-robin. Up to MAX_OUTSTANDING accepted requests are tracked in an in-order owner FIFO, so each response returns to the port that issued it.

## Interface
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MAX_OUTSTANDING, 4, depth of the owner FIFO; power of two, ≥2
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  asynchronous, active-low reset
- imem_req_vld_i / imem_req_rdy_o  in/out  1  fetch request handshake
- imem_req_addr_i  in  ADDR_W  fetch address
- imem_resp_vld_o  out  1  fetch response valid
- imem_resp_data_o  out  DATA_W  fetch data
- imem_resp_err_o  out  1  fetch response error
- dmem_req_vld_i / dmem_req_rdy_o  in/out  1  data request handshake
- dmem_req_addr_i  in  ADDR_W  data address
- dmem_req_w_en_i  in  1  write enable
- dmem_req_w_be_i  in  DATA_W/8  write byte enables
- dmem_req_w_data_i  in  DATA_W  write data
- dmem_resp_vld_o, dmem_resp_err_o  out  1  data response valid / error
- dmem_resp_r_data_o  out  DATA_W  read data
- mem_req_vld_o / mem_req_rdy_i  out/in  1  downstream request handshake
- mem_req_addr_o, mem_req_w_en_o, mem_req_w_be_o, mem_req_w_data_o  out  ADDR_W/1/DATA_W/8/DATA_W  downstream payload
- mem_resp_vld_i, mem_resp_err_i  in  1  downstream response valid / error
- mem_resp_r_data_i  in  DATA_W  downstream read data
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy
- spurious_resp_o  out  1  sticky flag: a response arrived while the FIFO was empty

## Operation
- State consists of:
  - owner FIFO (1 bit per entry: 0 = imem, 1 = dmem) with read/write pointers and a count;
  - `prio` bit (1 = dmem preferred);
  - `lock` bit plus `lock_owner`;
  - `spurious` sticky bit.
- Accepting a request (push) requires `count < MAX_OUTSTANDING`. A pop in the same cycle does not free a slot for that cycle's push.
- Arbitration happens only when `lock = 0` and the FIFO is not full:
  - one requester valid: it wins;
  - both valid: the port selected by `prio` wins.
- When `lock = 1`, the winner is `lock_owner`, regardless of the other port.
- `mem_req_vld_o` equals the winner's valid. The payload is muxed from the winner:
  - an imem winner drives `w_en = 0`, `w_be = 0`, `w_data = 0`;
  - with no winner, the payload is all zeros.
- `<winner>_req_rdy_o = mem_req_rdy_i & ~full`. The loser's ready is 0.
- On handshake (`mem_req_vld_o & mem_req_rdy_i`):
  - push the owner bit;
  - set `prio` to the other port;
  - clear `lock`.
- If `mem_req_vld_o & ~mem_req_rdy_i`: set `lock = 1` and `lock_owner = winner`, which keeps the downstream payload stable. Upstream ports must hold valid and payload until ready.
- On `mem_resp_vld_i` with the FIFO non-empty:
  - pop the head;
  - assert the head owner's `resp_vld_o`;
  - drive its `resp_err_o` from `mem_resp_err_i`.
- `imem_resp_data_o` and `dmem_resp_r_data_o` both mirror `mem_resp_r_data_i` unconditionally.
- On `mem_resp_vld_i` with the FIFO empty: drop the response (no upstream `resp_vld`) and set `spurious`. It is cleared only by reset.
- Push and pop in the same cycle leave `count` unchanged and advance both pointers. Pointers wrap modulo MAX_OUTSTANDING.

## Timing
- Reset values, asynchronous on `rst_ni` low: `count`, pointers, `lock` and `spurious` are 0; `prio` is 1. All `*_vld_o` and `*_rdy_o` are 0 while `rst_ni` is low.
- The request path is combinational: upstream to downstream adds zero cycles of latency.
- The response path is combinational: `mem_resp_vld_i` to `*_resp_vld_o` in the same cycle.
- Total latency equals the downstream latency. Throughput is one request per cycle while the FIFO is not full.
- `outstanding_o` is registered and reflects pushes and pops on the next cycle.
- Reset mid-operation: the FIFO empties. Responses that later arrive for pre-reset requests are flagged spurious.

## Test plan
- Only imem valid, `mem_req_rdy_i = 1`, addr 0x100; response 1 cycle later with data 0xDEADBEEF → `imem_resp_vld_o = 1`, data 0xDEADBEEF, `dmem_resp_vld_o = 0`.
- Both ports valid for 4 consecutive cycles, always ready → grants alternate dmem, imem, dmem, imem (`prio` resets to dmem).
- dmem write (addr 0x40, be 0xF) with `mem_req_rdy_i = 0` for 3 cycles while imem also requests → payload stays fixed on the dmem write; imem is granted only on the cycle after acceptance.
- Issue 4 requests with no responses (MAX_OUTSTANDING = 4) → `outstanding_o = 4`, both `rdy = 0` even with `mem_req_rdy_i = 1`. Then one response → pop, and a push is allowed the next cycle.
- Interleaved requests I, D, D, I, then 4 responses, the second with `mem_resp_err_i = 1` → routed imem, dmem(err), dmem, imem in order.
- Assert `rst_ni` with 2 outstanding, release it, then inject `mem_resp_vld_i` → no upstream valid and `spurious_resp_o = 1`.

Source files
------------

// File: rtl/xrv1_mem_arb_if.sv
// Valid/ready request and valid-only response bundle shared by the fetch port,
// the data port and the downstream memory port of the XRV1 memory arbiter.
interface xrv1_mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_vld;
    logic                  req_rdy;
    logic [ADDR_W-1:0]     req_addr;
    logic                  req_w_en;
    logic [DATA_W/8-1:0]   req_w_be;
    logic [DATA_W-1:0]     req_w_data;
    logic                  resp_vld;
    logic                  resp_err;
    logic [DATA_W-1:0]     resp_r_data;

    // The requester is the master; the side that accepts requests and returns responses is the slave.
    modport master (
        output req_vld, req_addr, req_w_en, req_w_be, req_w_data,
        input  req_rdy, resp_vld, resp_err, resp_r_data
    );

    modport slave (
        input  req_vld, req_addr, req_w_en, req_w_be, req_w_data,
        output req_rdy, resp_vld, resp_err, resp_r_data
    );
endinterface

// File: rtl/xrv1_mem_arb.sv
// Round-robin 2:1 arbiter sharing one memory port between XRV1 fetch and data ports;
// an in-order owner FIFO steers each response back to the port that issued it.
module xrv1_mem_arb #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    xrv1_mem_arb_if.slave                      imem,
    xrv1_mem_arb_if.slave                      dmem,
    xrv1_mem_arb_if.master                     mem,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               spurious_resp_o
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int BE_W  = DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_OPEN,
        ARB_HOLD_IMEM,
        ARB_HOLD_DMEM
    } arb_state_e;

    arb_state_e                  state_q, state_d;
    logic                        prio_q;
    logic                        spurious_q;
    logic [MAX_OUTSTANDING-1:0]  owner_q;
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]            count_q;

    logic                        full, empty;
    logic                        grant_imem, grant_dmem;
    logic                        req_vld, handshake, push, pop, head_owner;
    logic [ADDR_W-1:0]           sel_addr;
    logic                        sel_w_en;
    logic [BE_W-1:0]             sel_w_be;
    logic [DATA_W-1:0]           sel_w_data;

    assign full       = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty      = (count_q == '0);
    assign req_vld    = grant_imem | grant_dmem;
    assign handshake  = req_vld & mem.req_rdy;
    assign push       = handshake & ~full;
    assign pop        = rst_ni & mem.resp_vld & ~empty;
    assign head_owner = owner_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_OPEN;
        end else begin
            state_q <= state_d;
        end
    end

    // A stalled grant is held until the downstream port accepts it, keeping its payload stable.
    always_comb begin
        state_d = state_q;
        if (handshake) begin
            state_d = ARB_OPEN;
        end else if (req_vld) begin
            state_d = grant_dmem ? ARB_HOLD_DMEM : ARB_HOLD_IMEM;
        end
    end

    always_comb begin
        grant_imem = 1'b0;
        grant_dmem = 1'b0;
        if (rst_ni) begin
            case (state_q)
                ARB_HOLD_IMEM: grant_imem = imem.req_vld;
                ARB_HOLD_DMEM: grant_dmem = dmem.req_vld;
                default: begin
                    if (!full) begin
                        if (imem.req_vld && dmem.req_vld) begin
                            grant_dmem = prio_q;
                            grant_imem = ~prio_q;
                        end else begin
                            grant_imem = imem.req_vld;
                            grant_dmem = dmem.req_vld;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        sel_addr   = '0;
        sel_w_en   = 1'b0;
        sel_w_be   = '0;
        sel_w_data = '0;
        if (grant_dmem) begin
            sel_addr   = dmem.req_addr;
            sel_w_en   = dmem.req_w_en;
            sel_w_be   = dmem.req_w_be;
            sel_w_data = dmem.req_w_data;
        end else if (grant_imem) begin
            sel_addr   = imem.req_addr;
        end
    end

    assign mem.req_vld    = req_vld;
    assign mem.req_addr   = sel_addr;
    assign mem.req_w_en   = sel_w_en;
    assign mem.req_w_be   = sel_w_be;
    assign mem.req_w_data = sel_w_data;

    assign imem.req_rdy   = grant_imem & mem.req_rdy & ~full;
    assign dmem.req_rdy   = grant_dmem & mem.req_rdy & ~full;

    assign imem.resp_vld    = pop & ~head_owner;
    assign imem.resp_err    = pop & ~head_owner & mem.resp_err;
    assign imem.resp_r_data = mem.resp_r_data;
    assign dmem.resp_vld    = pop & head_owner;
    assign dmem.resp_err    = pop & head_owner & mem.resp_err;
    assign dmem.resp_r_data = mem.resp_r_data;

    // Owner FIFO: one bit per accepted request, 1 marks a data-port request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            prio_q     <= 1'b1;
            spurious_q <= 1'b0;
        end else begin
            if (push) begin
                owner_q[wr_ptr_q] <= grant_dmem;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
                prio_q            <= grant_imem;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (mem.resp_vld && empty) begin
                spurious_q <= 1'b1;
            end
        end
    end

    assign outstanding_o   = count_q;
    assign spurious_resp_o = spurious_q;
endmodule

// File: tb/tb_xrv1_mem_arb.sv
// Directed self-checking bench for xrv1_mem_arb: arbitration order, lock on stall,
// owner-FIFO routing, full back-pressure and post-reset spurious responses.
module tb_xrv1_mem_arb;
    logic       clk_i;
    logic       rst_ni;
    logic [2:0] outstanding_o;
    logic       spurious_resp_o;
    int         errors;
    int         checks;

    xrv1_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) imem_bus ();
    xrv1_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) dmem_bus ();
    xrv1_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    xrv1_mem_arb #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .imem            (imem_bus.slave),
        .dmem            (dmem_bus.slave),
        .mem             (mem_bus.master),
        .outstanding_o   (outstanding_o),
        .spurious_resp_o (spurious_resp_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Inputs change just after the falling edge so comparisons sit mid-cycle, away from the rising edge.
    task automatic applyStimulus(
        input logic iv, input logic [31:0] ia,
        input logic dv, input logic [31:0] da, input logic dwe, input logic [3:0] dbe, input logic [31:0] dwd,
        input logic mrdy, input logic rv, input logic rerr, input logic [31:0] rdata);
        @(negedge clk_i);
        imem_bus.req_vld    = iv;
        imem_bus.req_addr   = ia;
        dmem_bus.req_vld    = dv;
        dmem_bus.req_addr   = da;
        dmem_bus.req_w_en   = dwe;
        dmem_bus.req_w_be   = dbe;
        dmem_bus.req_w_data = dwd;
        mem_bus.req_rdy     = mrdy;
        mem_bus.resp_vld    = rv;
        mem_bus.resp_err    = rerr;
        mem_bus.resp_r_data = rdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_ni = 1'b0;
        imem_bus.req_vld = 1'b0;  imem_bus.req_addr = '0;  imem_bus.req_w_en = 1'b0;
        imem_bus.req_w_be = '0;   imem_bus.req_w_data = '0;
        dmem_bus.req_vld = 1'b0;  dmem_bus.req_addr = '0;  dmem_bus.req_w_en = 1'b0;
        dmem_bus.req_w_be = '0;   dmem_bus.req_w_data = '0;
        mem_bus.req_rdy = 1'b0;   mem_bus.resp_vld = 1'b0; mem_bus.resp_err = 1'b0;
        mem_bus.resp_r_data = '0;

        // Reset holds every valid and ready low even with requests pending.
        #3;
        imem_bus.req_vld = 1'b1;
        mem_bus.req_rdy  = 1'b1;
        #1;
        checkOutput("rst_mem_vld",   32'(mem_bus.req_vld), 0);
        checkOutput("rst_imem_rdy",  32'(imem_bus.req_rdy), 0);
        checkOutput("rst_count",     32'(outstanding_o), 0);
        checkOutput("rst_spurious",  32'(spurious_resp_o), 0);
        imem_bus.req_vld = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single fetch, response one cycle later.
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("t1_mem_vld",   32'(mem_bus.req_vld), 1);
        checkOutput("t1_mem_addr",  mem_bus.req_addr, 32'h100);
        checkOutput("t1_mem_wen",   32'(mem_bus.req_w_en), 0);
        checkOutput("t1_imem_rdy",  32'(imem_bus.req_rdy), 1);
        checkOutput("t1_dmem_rdy",  32'(dmem_bus.req_rdy), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'hDEADBEEF);
        checkOutput("t1_count",     32'(outstanding_o), 1);
        checkOutput("t1_imem_rvld", 32'(imem_bus.resp_vld), 1);
        checkOutput("t1_imem_data", imem_bus.resp_r_data, 32'hDEADBEEF);
        checkOutput("t1_dmem_rvld", 32'(dmem_bus.resp_vld), 0);

        // Both ports request continuously: dmem, imem, dmem, imem.
        applyStimulus(1, 32'h200, 1, 32'h300, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("rr0_count",    32'(outstanding_o), 0);
        checkOutput("rr0_dmem_rdy", 32'(dmem_bus.req_rdy), 1);
        checkOutput("rr0_imem_rdy", 32'(imem_bus.req_rdy), 0);
        checkOutput("rr0_addr",     mem_bus.req_addr, 32'h300);
        applyStimulus(1, 32'h200, 1, 32'h300, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("rr1_imem_rdy", 32'(imem_bus.req_rdy), 1);
        checkOutput("rr1_addr",     mem_bus.req_addr, 32'h200);
        applyStimulus(1, 32'h200, 1, 32'h300, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("rr2_dmem_rdy", 32'(dmem_bus.req_rdy), 1);
        checkOutput("rr2_addr",     mem_bus.req_addr, 32'h300);
        applyStimulus(1, 32'h200, 1, 32'h300, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("rr3_imem_rdy", 32'(imem_bus.req_rdy), 1);
        checkOutput("rr3_addr",     mem_bus.req_addr, 32'h200);

        // FIFO full (D,I,D,I): no grants; a same-cycle pop does not open a slot.
        applyStimulus(1, 32'h200, 1, 32'h300, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("full_count",    32'(outstanding_o), 4);
        checkOutput("full_imem_rdy", 32'(imem_bus.req_rdy), 0);
        checkOutput("full_dmem_rdy", 32'(dmem_bus.req_rdy), 0);
        checkOutput("full_mem_vld",  32'(mem_bus.req_vld), 0);
        applyStimulus(1, 32'h200, 1, 32'h300, 0, 0, 0, 1, 1, 0, 32'h11);
        checkOutput("full_pop_dvld", 32'(dmem_bus.resp_vld), 1);
        checkOutput("full_pop_ivld", 32'(imem_bus.resp_vld), 0);
        checkOutput("full_pop_drdy", 32'(dmem_bus.req_rdy), 0);
        applyStimulus(1, 32'h200, 1, 32'h300, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("refill_count",  32'(outstanding_o), 3);
        checkOutput("refill_drdy",   32'(dmem_bus.req_rdy), 1);
        checkOutput("refill_irdy",   32'(imem_bus.req_rdy), 0);

        // Drain I,D,I,D with an error on the second response.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h21);
        checkOutput("dr0_count", 32'(outstanding_o), 4);
        checkOutput("dr0_ivld",  32'(imem_bus.resp_vld), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h22);
        checkOutput("dr1_dvld",  32'(dmem_bus.resp_vld), 1);
        checkOutput("dr1_derr",  32'(dmem_bus.resp_err), 1);
        checkOutput("dr1_ierr",  32'(imem_bus.resp_err), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h23);
        checkOutput("dr2_ivld",  32'(imem_bus.resp_vld), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h24);
        checkOutput("dr3_dvld",  32'(dmem_bus.resp_vld), 1);
        checkOutput("dr3_derr",  32'(dmem_bus.resp_err), 0);

        // Stalled dmem write stays locked on the bus while imem waits.
        applyStimulus(0, 0, 1, 32'h40, 1, 4'hF, 32'h12345678, 0, 0, 0, 0);
        checkOutput("lk0_count", 32'(outstanding_o), 0);
        checkOutput("lk0_vld",   32'(mem_bus.req_vld), 1);
        checkOutput("lk0_addr",  mem_bus.req_addr, 32'h40);
        checkOutput("lk0_wen",   32'(mem_bus.req_w_en), 1);
        checkOutput("lk0_be",    32'(mem_bus.req_w_be), 32'hF);
        checkOutput("lk0_drdy",  32'(dmem_bus.req_rdy), 0);
        applyStimulus(1, 32'h500, 1, 32'h40, 1, 4'hF, 32'h12345678, 0, 0, 0, 0);
        checkOutput("lk1_addr",  mem_bus.req_addr, 32'h40);
        checkOutput("lk1_wdata", mem_bus.req_w_data, 32'h12345678);
        checkOutput("lk1_irdy",  32'(imem_bus.req_rdy), 0);
        applyStimulus(1, 32'h500, 1, 32'h40, 1, 4'hF, 32'h12345678, 0, 0, 0, 0);
        checkOutput("lk2_addr",  mem_bus.req_addr, 32'h40);
        applyStimulus(1, 32'h500, 1, 32'h40, 1, 4'hF, 32'h12345678, 1, 0, 0, 0);
        checkOutput("lk3_drdy",  32'(dmem_bus.req_rdy), 1);
        checkOutput("lk3_irdy",  32'(imem_bus.req_rdy), 0);
        applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("lk4_irdy",  32'(imem_bus.req_rdy), 1);
        checkOutput("lk4_addr",  mem_bus.req_addr, 32'h500);
        checkOutput("lk4_wen",   32'(mem_bus.req_w_en), 0);
        checkOutput("lk4_be",    32'(mem_bus.req_w_be), 0);
        checkOutput("lk4_wdata", mem_bus.req_w_data, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h31);
        checkOutput("lk5_count", 32'(outstanding_o), 2);
        checkOutput("lk5_dvld",  32'(dmem_bus.resp_vld), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h32);
        checkOutput("lk6_ivld",  32'(imem_bus.resp_vld), 1);

        // Interleaved I,D,D,I then in-order routing with an error on the second.
        applyStimulus(1, 32'h700, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("il0_irdy", 32'(imem_bus.req_rdy), 1);
        applyStimulus(0, 0, 1, 32'h704, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("il1_drdy", 32'(dmem_bus.req_rdy), 1);
        applyStimulus(0, 0, 1, 32'h708, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("il2_drdy", 32'(dmem_bus.req_rdy), 1);
        applyStimulus(1, 32'h70C, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("il3_irdy", 32'(imem_bus.req_rdy), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h41);
        checkOutput("ir0_count", 32'(outstanding_o), 4);
        checkOutput("ir0_ivld",  32'(imem_bus.resp_vld), 1);
        checkOutput("ir0_dvld",  32'(dmem_bus.resp_vld), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h42);
        checkOutput("ir1_dvld",  32'(dmem_bus.resp_vld), 1);
        checkOutput("ir1_derr",  32'(dmem_bus.resp_err), 1);
        checkOutput("ir1_ddata", dmem_bus.resp_r_data, 32'h42);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h43);
        checkOutput("ir2_dvld",  32'(dmem_bus.resp_vld), 1);
        checkOutput("ir2_derr",  32'(dmem_bus.resp_err), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h44);
        checkOutput("ir3_ivld",  32'(imem_bus.resp_vld), 1);
        checkOutput("ir3_ierr",  32'(imem_bus.resp_err), 0);

        // Simultaneous push and pop keep the count, then reset with requests in flight.
        applyStimulus(1, 32'h600, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("rs0_count", 32'(outstanding_o), 0);
        applyStimulus(0, 0, 1, 32'h604, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 32'h608, 0, 0, 0, 0, 0, 1, 1, 0, 32'h51);
        checkOutput("pp_count",  32'(outstanding_o), 2);
        checkOutput("pp_ivld",   32'(imem_bus.resp_vld), 1);
        checkOutput("pp_irdy",   32'(imem_bus.req_rdy), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("pp_count2", 32'(outstanding_o), 2);
        #1;
        rst_ni = 1'b0;
        imem_bus.req_vld = 1'b1;
        #1;
        checkOutput("mr_count",   32'(outstanding_o), 0);
        checkOutput("mr_mem_vld", 32'(mem_bus.req_vld), 0);
        imem_bus.req_vld = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h61);
        checkOutput("sp_ivld",  32'(imem_bus.resp_vld), 0);
        checkOutput("sp_dvld",  32'(dmem_bus.resp_vld), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("sp_flag",  32'(spurious_resp_o), 1);
        checkOutput("sp_count", 32'(outstanding_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
